// File: rtl/alu_iterative.sv
// alu_iterative: RV32I integer execution unit with valid/ready handshakes.
// Single-cycle ops resolve on the acceptance edge; shifts run serially,
// one bit per cycle, through a shared accumulator.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; in_ready high
// SHIFT | serial shift in progress; cnt holds the remaining bit count
// DONE  | result/zero/illegal held; out_valid high until out_ready
module alu_iterative #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alucontrol,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_SRL  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  localparam logic [SHW-1:0] CNT_ZERO = '0;
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] acc, acc_shf, calc, result_r;
  logic [SHW-1:0]  cnt, amt;
  logic [3:0]      op;
  logic            zero_r, illegal_r;
  logic            legal, is_shift, accept, start_shift;

  assign amt         = b[SHW-1:0];
  assign accept      = in_valid && (state == IDLE);
  assign start_shift = accept && is_shift && (amt != CNT_ZERO);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;

  // Single-cycle result from the live inputs; a shift by zero passes a through.
  always_comb begin
    calc     = '0;
    legal    = 1'b1;
    is_shift = 1'b0;
    case (alucontrol)
      OP_AND:  calc = a & b;
      OP_OR:   calc = a | b;
      OP_ADD:  calc = a + b;
      OP_XOR:  calc = a ^ b;
      OP_SUB:  calc = a - b;
      OP_SLT:  calc = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: calc = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: begin
        calc     = a;
        is_shift = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // One-bit step of the serial shifter, selected by the latched op.
  always_comb begin
    acc_shf = acc;
    case (op)
      OP_SLL:  acc_shf = {acc[XLEN-2:0], 1'b0};
      OP_SRL:  acc_shf = {1'b0, acc[XLEN-1:1]};
      OP_SRA:  acc_shf = {acc[XLEN-1], acc[XLEN-1:1]};
      default: acc_shf = acc;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt == CNT_ONE) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath: latch on acceptance, step the shifter, register the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      op        <= '0;
      result_r  <= '0;
      zero_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else if (accept) begin
      op <= alucontrol;
      if (start_shift) begin
        acc <= a;
        cnt <= amt;
      end else begin
        result_r  <= calc;
        zero_r    <= (calc == '0);
        illegal_r <= ~legal;
      end
    end else if (state == SHIFT) begin
      acc <= acc_shf;
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        result_r  <= acc_shf;
        zero_r    <= (acc_shf == '0);
        illegal_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: scoreboard of expected results,
// latency, backpressure, illegal codes and mid-operation reset.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [3:0]  alucontrol;
  logic [31:0] a, b, result;

  typedef struct {
    logic [31:0] res;
    logic        zr;
    logic        il;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_iterative #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the operation table.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   k;
    k     = int'(y[4:0]);
    e.il  = 1'b0;
    e.lat = 1;
    case (c)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: e.res = x + y;
      4'b0011: e.res = x ^ y;
      4'b0110: e.res = x - y;
      4'b1010: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1011: e.res = (x < y) ? 32'd1 : 32'd0;
      4'b1001: begin e.res = x << k;            e.lat = (k == 0) ? 1 : k + 1; end
      4'b1100: begin e.res = x >> k;            e.lat = (k == 0) ? 1 : k + 1; end
      4'b1101: begin e.res = $signed(x) >>> k;  e.lat = (k == 0) ? 1 : k + 1; end
      default: begin e.res = 32'd0; e.il = 1'b1; end
    endcase
    e.zr = (e.res == 32'd0);
    return e;
  endfunction

  // Entered just after a negedge; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    int   n, w;
    exp_t e;
    alucontrol = c; a = x; b = y; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(model(c, x, y));
    @(negedge clk);
    in_valid = 1'b0; alucontrol = ~c; a = ~x; b = ~y;
    n = 1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("latency", n, e.lat);
      chk("result", result, e.res);
      chk("zero", {31'd0, zero}, {31'd0, e.zr});
      chk("illegal", {31'd0, illegal}, {31'd0, e.il});
    end
  endtask

  // Hold the result for 'stall' cycles (optionally presenting a competing
  // request), then hand it off and confirm the return to IDLE.
  task automatic finish_op(input int stall, input logic bp, input logic [3:0] c2,
                           input logic [31:0] x2, input logic [31:0] y2);
    logic [31:0] r0;
    logic        z0, i0;
    r0 = result; z0 = zero; i0 = illegal;
    for (int i = 0; i < stall; i++) begin
      if (bp) begin alucontrol = c2; a = x2; b = y2; in_valid = 1'b1; end
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_result", result, r0);
      chk("stall_flags", {30'd0, zero, illegal}, {30'd0, z0, i0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_valid", {31'd0, out_valid}, 32'd0);
    chk("handoff_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int hits;
    logic [3:0] codes [10];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
              4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alucontrol = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'd0, zero, illegal}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(4'b0010, 32'h5, 32'h3);                    finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);
    run_op(4'b0110, 32'h7, 32'h7);                    finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);
    run_op(4'b1010, 32'hFFFF_FFFF, 32'h1);            finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);
    run_op(4'b1011, 32'hFFFF_FFFF, 32'h1);            finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);
    run_op(4'b1101, 32'h8000_0000, 32'd31);           finish_op(2, 1'b0, 4'd0, 32'd0, 32'd0);
    run_op(4'b1100, 32'h8000_0000, 32'd31);           finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);
    run_op(4'b1001, 32'h1, 32'h20);                   finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);
    run_op(4'b1001, 32'h1, 32'd1);                    finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);

    // Backpressure with a competing request held during the stall.
    run_op(4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000);
    finish_op(5, 1'b1, 4'b0010, 32'h10, 32'h20);
    run_op(4'b0010, 32'h10, 32'h20);                  finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);

    run_op(4'b0111, 32'h1234_5678, 32'h0);            finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);

    // Reset in the middle of a 20-bit shift.
    alucontrol = 4'b1001; a = 32'h1; b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    hits = 0;
    for (int i = 2; i < 10; i++) begin
      if (out_valid) hits++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_result", result, 32'd0);
    for (int i = 0; i < 25; i++) begin
      if (out_valid) hits++;
      @(negedge clk);
    end
    chk("midrst_no_valid", hits, 0);
    run_op(4'b0010, 32'h1, 32'h1);                    finish_op(0, 1'b0, 4'd0, 32'd0, 32'd0);

    // Random mix, including serial shifts and illegal codes.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] c;
      c = (i % 4 == 3) ? 4'(($urandom_range(0, 3) * 2) + 4'd7) : codes[$urandom_range(0, 9)];
      run_op(c, $urandom, $urandom);
      finish_op(int'($urandom_range(0, 2)), 1'b0, 4'd0, 32'd0, 32'd0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
